// File: rtl/vga_sync_gen_if.sv
// ----------------------------------------------------------------------------
// vga_sync_gen_if -- timing bundle between a raster sync generator and the
// logic that consumes its position and sync strobes.
//
//   ce          : pixel enable. The consumer drives it and the generator samples it.
//   hcounter    : current pixel column (12 bits).
//   vcounter    : current line (11 bits).
//   hsync/vsync : sync pulses at the configured polarity.
//   blank       : 1 while the position is outside the visible area.
//   line_start  : 1 for the position entered by a horizontal wrap.
//   frame_start : 1 for the position entered by a frame wrap.
// ----------------------------------------------------------------------------
interface vga_sync_gen_if;
  logic        ce;
  logic [11:0] hcounter;
  logic [10:0] vcounter;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  ce,
    output hcounter, vcounter, hsync, vsync, blank, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hcounter, vcounter, hsync, vsync, blank, line_start, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen -- parameterised raster timing generator.
//
// Ports:
//   clk : pixel-domain clock.
//   rst : asynchronous active-high reset.
//   vga : vga_sync_gen_if.master. This port carries the ce input and the
//         registered counter and strobe outputs.
//
// The horizontal counter advances on every ce-qualified edge. The vertical
// counter advances on the edge where the horizontal counter wraps. Every
// strobe is registered from the *next* counter values, so each strobe always
// describes the position that is presented in the same cycle.
// ----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FRONT   = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BACK    = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 38,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] HS_START   = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [11:0] hcount_q;
  logic [10:0] vcount_q;
  logic        hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;

  logic        h_wrap, v_wrap;
  logic [11:0] h_next;
  logic [10:0] v_next;

  // Next position. The counters wrap at TOTAL-1, so they never move past it.
  always_comb begin
    h_wrap = (hcount_q == H_LAST);
    v_wrap = h_wrap && (vcount_q == V_LAST);
    h_next = h_wrap ? 12'd0 : hcount_q + 12'd1;
    v_next = vcount_q;
    if (v_wrap)      v_next = 11'd0;
    else if (h_wrap) v_next = vcount_q + 11'd1;
  end

  // NOTE: the strobes are decoded from h_next/v_next rather than from the
  // current counters. This lets strobes and counters load on the same edge,
  // so the registered outputs stay in step with no one-cycle skew.
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vga.ce) begin
      hcount_q      <= h_next;
      vcount_q      <= v_next;
      hsync_q       <= (h_next >= HS_START && h_next < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= (v_next >= VS_START && v_next < VS_END) ? SYNC_POL : ~SYNC_POL;
      blank_q       <= (h_next >= H_VIS) || (v_next >= V_VIS);
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign vga.hcounter    = hcount_q;
  assign vga.vcounter    = vcount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank       = blank_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen -- self-checking bench for vga_sync_gen.
//
// Three instances share one clock:
//   u0 : default 1280x1024 timing, ce held high.
//   u1 : 640x480 timing with active-low sync, ce held high.
//   u2 : tiny 15x11 raster with ce toggling. This instance covers whole
//        frames, hold behaviour and the asynchronous reset.
// The reference model maps the number of ce-qualified edges since reset
// straight onto a raster position, using division and modulo.
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct packed {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic [11:0] h;
    logic [10:0] v;
    logic        hs, vs, bl, ls, fs;
  } obs_t;

  localparam cfg_t C0 = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1};
  localparam cfg_t C1 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  localparam cfg_t C2 = '{8, 2, 3, 2, 6, 1, 2, 2, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   checks = 0;
  int   failures = 0;

  vga_sync_gen_if if0 ();
  vga_sync_gen_if if1 ();
  vga_sync_gen_if if2 ();

  vga_sync_gen u0 (.clk(clk), .rst(rst0), .vga(if0.master));

  vga_sync_gen #(
    .H_VISIBLE(C1.hv), .H_FRONT(C1.hf), .H_SYNC(C1.hs), .H_BACK(C1.hb),
    .V_VISIBLE(C1.vv), .V_FRONT(C1.vf), .V_SYNC(C1.vs), .V_BACK(C1.vb),
    .SYNC_POL(C1.pol)
  ) u1 (.clk(clk), .rst(rst1), .vga(if1.master));

  vga_sync_gen #(
    .H_VISIBLE(C2.hv), .H_FRONT(C2.hf), .H_SYNC(C2.hs), .H_BACK(C2.hb),
    .V_VISIBLE(C2.vv), .V_FRONT(C2.vf), .V_SYNC(C2.vs), .V_BACK(C2.vb),
    .SYNC_POL(C2.pol)
  ) u2 (.clk(clk), .rst(rst2), .vga(if2.master));

  obs_t o0, o1, o2;
  assign o0 = {if0.hcounter, if0.vcounter, if0.hsync, if0.vsync, if0.blank, if0.line_start, if0.frame_start};
  assign o1 = {if1.hcounter, if1.vcounter, if1.hsync, if1.vsync, if1.blank, if1.line_start, if1.frame_start};
  assign o2 = {if2.hcounter, if2.vcounter, if2.hsync, if2.vsync, if2.blank, if2.line_start, if2.frame_start};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position after n ce-qualified edges since reset.
  function automatic obs_t model(input cfg_t c, input longint n);
    obs_t   o;
    longint ht, vt, h, v;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    o.h  = 12'(h);
    o.v  = 11'(v);
    o.hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
    o.vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
    o.bl = (h >= c.hv) || (v >= c.vv);
    o.ls = (n > 0) && (h == 0);
    o.fs = (n > 0) && (h == 0) && (v == 0);
    return o;
  endfunction

  longint n0 = 0, n1 = 0, n2 = 0;
  always @(posedge clk or posedge rst0) if (rst0) n0 <= 0; else if (if0.ce) n0 <= n0 + 1;
  always @(posedge clk or posedge rst1) if (rst1) n1 <= 0; else if (if1.ce) n1 <= n1 + 1;
  always @(posedge clk or posedge rst2) if (rst2) n2 <= 0; else if (if2.ce) n2 <= n2 + 1;

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    check("u0 model", o0, model(C0, n0));
    check("u1 model", o1, model(C1, n1));
    check("u2 model", o2, model(C2, n2));
  end

  int  hs0_cnt = 0, hs1_cnt = 0;
  int  fs2_first = -1, fs2_second = -1;
  bit  fs2_prev = 1'b0;
  bit  found;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.ce = 1'b1; if1.ce = 1'b1; if2.ce = 1'b1;

    // Reset holds the idle state even while ce is high and the clock runs.
    repeat (3) @(negedge clk);
    check("u0 rst h", if0.hcounter, 0);
    check("u0 rst hsync", if0.hsync, 0);
    check("u0 rst blank", if0.blank, 0);
    check("u1 rst hsync", if1.hsync, 1);
    check("u1 rst vsync", if1.vsync, 1);
    check("u2 rst ls", if2.line_start, 0);
    #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    for (int i = 1; i <= 1700; i++) begin
      @(negedge clk);
      if (i < 1688 && if0.hsync) hs0_cnt++;
      if (i < 800 && !if1.hsync) hs1_cnt++;
      if (if2.frame_start && !fs2_prev) begin
        if (fs2_first < 0) fs2_first = i;
        else if (fs2_second < 0) fs2_second = i;
      end
      fs2_prev = if2.frame_start;
      case (i)
        1: begin
          check("u0 first h", if0.hcounter, 1);
          check("u0 first v", if0.vcounter, 0);
          check("u0 first ls", if0.line_start, 0);
          check("u0 first fs", if0.frame_start, 0);
        end
        149:  check("u2 blank (0,5)", if2.blank, 0);
        179:  check("u2 blank (0,6)", if2.blank, 1);
        209:  check("u2 vsync (0,7)", if2.vsync, 1);
        267:  check("u2 vsync (14,8)", if2.vsync, 1);
        269:  check("u2 vsync (0,9)", if2.vsync, 0);
        327:  check("u2 blank (14,10)", if2.blank, 1);
        639:  check("u1 blank 639", if1.blank, 0);
        640:  check("u1 blank 640", if1.blank, 1);
        655:  check("u1 hsync 655", if1.hsync, 1);
        656:  check("u1 hsync 656", if1.hsync, 0);
        751:  check("u1 hsync 751", if1.hsync, 0);
        752:  check("u1 hsync 752", if1.hsync, 1);
        800: begin
          check("u1 wrap h", if1.hcounter, 0);
          check("u1 wrap v", if1.vcounter, 1);
          check("u1 wrap ls", if1.line_start, 1);
        end
        1279: check("u0 blank (1279,0)", if0.blank, 0);
        1280: check("u0 blank (1280,0)", if0.blank, 1);
        1327: check("u0 hsync 1327", if0.hsync, 0);
        1328: check("u0 hsync 1328", if0.hsync, 1);
        1439: check("u0 hsync 1439", if0.hsync, 1);
        1440: check("u0 hsync 1440", if0.hsync, 0);
        1687: check("u0 h 1687", if0.hcounter, 1687);
        1688: begin
          check("u0 wrap h", if0.hcounter, 0);
          check("u0 wrap v", if0.vcounter, 1);
          check("u0 wrap ls", if0.line_start, 1);
          check("u0 wrap fs", if0.frame_start, 0);
        end
        1689: check("u0 ls one cycle", if0.line_start, 0);
        default: ;
      endcase
      #1;
      if2.ce = ~if2.ce;
    end

    check("u0 hsync width", hs0_cnt, 112);
    check("u1 hsync width", hs1_cnt, 96);
    check("u2 first frame", fs2_first, 329);
    check("u2 frame period", fs2_second - fs2_first, 330);

    // Drive u2 to (11,7), where hsync and vsync are both active, then reset
    // it between clock edges.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (if2.hcounter == 12'd11 && if2.vcounter == 11'd7) found = 1'b1;
      else begin
        #1;
        if2.ce = ~if2.ce;
      end
    end
    check("u2 reach (11,7)", found, 1);
    check("u2 pre-rst hsync", if2.hsync, 1);
    check("u2 pre-rst vsync", if2.vsync, 1);
    #2 rst2 = 1'b1;
    #1;
    check("u2 async h", if2.hcounter, 0);
    check("u2 async v", if2.vcounter, 0);
    check("u2 async hsync", if2.hsync, 0);
    check("u2 async vsync", if2.vsync, 0);
    check("u2 async blank", if2.blank, 0);
    check("u2 async ls/fs", {if2.line_start, if2.frame_start}, 0);
    if2.ce = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst2 = 1'b0;
    @(negedge clk);
    check("u2 resume h", if2.hcounter, 1);
    check("u2 resume v", if2.vcounter, 0);
    check("u2 resume ls", if2.line_start, 0);
    for (int k = 0; k < 200; k++) begin
      #1 if2.ce = ~if2.ce;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; no other clock or reset inputs.
REQ-002 Parameter H_VISIBLE, default 1280, SHALL set the active pixels per line.
REQ-003 Parameter H_FRONT, default 48, SHALL set the horizontal front porch in pixels.
REQ-004 Parameter H_SYNC, default 112, SHALL set the hsync pulse width in pixels.
REQ-005 Parameter H_BACK, default 248, SHALL set the horizontal back porch in pixels (H_TOTAL = sum = 1688).
REQ-006 Parameter V_VISIBLE, default 1024, SHALL set the active lines per frame.
REQ-007 Parameter V_FRONT, default 1, SHALL set the vertical front porch in lines.
REQ-008 Parameter V_SYNC, default 3, SHALL set the vsync pulse width in lines.
REQ-009 Parameter V_BACK, default 38, SHALL set the vertical back porch in lines (V_TOTAL = sum = 1066).
REQ-010 Parameter SYNC_POL, default 1, SHALL set the active level of hsync and vsync.
REQ-011 Port clk, input, 1 bit: pixel-domain clock.
REQ-012 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-013 Port ce, input, 1 bit: pixel enable; all state advances only in cycles where ce=1.
REQ-014 Port hcounter, output, 12 bits: current pixel column, 0..H_TOTAL-1.
REQ-015 Port vcounter, output, 11 bits: current line, 0..V_TOTAL-1.
REQ-016 Port hsync, output, 1 bit: horizontal sync, level SYNC_POL when active.
REQ-017 Port vsync, output, 1 bit: vertical sync, level SYNC_POL when active.
REQ-018 Port blank, output, 1 bit: 1 when position is outside the visible area.
REQ-019 Port line_start, output, 1 bit: 1 while hcounter=0 following a horizontal wrap.
REQ-020 Port frame_start, output, 1 bit: 1 while hcounter=0 and vcounter=0 following a frame wrap.

Function
REQ-021 All outputs SHALL be registers; hsync, vsync, blank, line_start, frame_start SHALL always describe the hcounter/vcounter values presented in the same cycle (no skew).
REQ-022 On a ce=1 edge, hcounter SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-023 vcounter SHALL increment only on the edge where hcounter wraps; at V_TOTAL-1 (with hcounter wrap) it SHALL wrap to 0.
REQ-024 With ce=0 every register SHALL hold its value, including the pulse outputs.
REQ-025 hsync SHALL be active for H_VISIBLE+H_FRONT <= hcounter < H_VISIBLE+H_FRONT+H_SYNC (1328..1439 default), else inactive.
REQ-026 vsync SHALL be active for V_VISIBLE+V_FRONT <= vcounter < V_VISIBLE+V_FRONT+V_SYNC (1025..1027 default), else inactive.
REQ-027 blank SHALL be 1 when hcounter >= H_VISIBLE or vcounter >= V_VISIBLE, else 0.
REQ-028 line_start SHALL assert only for the counter state entered by a horizontal wrap; frame_start only for the state entered by a simultaneous horizontal and vertical wrap; each lasts exactly one ce-qualified cycle.
REQ-029 Counter comparisons SHALL use widths sufficient for H_TOTAL <= 4095 and V_TOTAL <= 2047; no overflow past TOTAL-1 is permitted.

Reset
REQ-030 While rst=1, regardless of clk or ce: hcounter=0, vcounter=0, blank=0, hsync=vsync=~SYNC_POL, line_start=0, frame_start=0.
REQ-031 After rst deasserts, the first ce=1 edge SHALL move to hcounter=1, vcounter=0; no frame_start or line_start is produced for the reset position.
REQ-032 rst asserted mid-frame (including during sync) SHALL force the REQ-030 values immediately, without waiting for a clock edge.

Verification
REQ-033 Reset release, ce=1 for 1688 cycles -> hcounter 0..1687 then 0, vcounter 0->1, line_start=1 exactly at that cycle, frame_start=0.
REQ-034 ce=1 continuous across one frame -> hsync active for exactly 112 cycles per line starting at hcounter=1328; vsync active for lines 1025..1027 only; frame_start=1 once per 1688*1066 = 1,799,408 cycles.
REQ-035 Check blank at (1279,0)=0, (1280,0)=1, (0,1023)=0, (0,1024)=1, (1687,1065)=1.
REQ-036 ce toggled 1,0,1,0 -> counters and all outputs advance on ce=1 cycles only; frame period doubles to 3,598,816 clk cycles.
REQ-037 rst pulsed asynchronously at (1400,1026) (hsync and vsync active) -> all outputs match REQ-030 before the next clk edge; the count resumes from (0,0).
REQ-038 Parameters overridden to 640/16/96/48 and 480/10/2/33 with SYNC_POL=0 -> line 800 cycles, frame 525 lines, hsync low at 656..751, vsync low at lines 490..491.
